// File: rtl/rst_seq_pkg.sv
// Shared constants for the reset sequencer: FSM state encodings,
// reset-cause codes and a small elaboration-time helper.
package rst_seq_pkg;

   // FSM state encodings (2 bits)
   localparam logic [1:0] ST_LOCK_WAIT = 2'b00;
   localparam logic [1:0] ST_CORE_UP   = 2'b01;
   localparam logic [1:0] ST_RUN       = 2'b10;
   localparam logic [1:0] ST_SW_RST    = 2'b11;

   // Cause of the most recent reset, as seen on rst_cause
   typedef enum logic [1:0] {
      CAUSE_POR  = 2'b00,
      CAUSE_LOCK = 2'b01,
      CAUSE_SW   = 2'b10
   } rst_cause_e;

   // Largest of three timer lengths; sizes the shared down-stream counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Lock/request inputs and reset/cause outputs of the reset sequencer.
// The clock-domain source (DCM model) side is the master; rst_seq is the slave.
interface rst_seq_if;
   logic       locked;
   logic       sw_rst_req;
   logic       chip_reset_;
   logic       periph_reset_;
   logic [1:0] rst_cause;

   modport master (
      output locked,
      output sw_rst_req,
      input  chip_reset_,
      input  periph_reset_,
      input  rst_cause
   );

   modport slave (
      input  locked,
      input  sw_rst_req,
      output chip_reset_,
      output periph_reset_,
      output rst_cause
   );
endinterface

// File: rtl/rst_seq_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Every stage resets to 0 so a freshly reset system never sees a stale lock.
module rst_seq_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer downstream of the DCM. Holds core and peripheral resets
// until lock has been stable for LOCK_WAIT cycles, releases the core first and
// the peripherals PERIPH_DELAY cycles later, and re-enters the sequence on
// lock loss or a software request while recording the cause.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_LOCK_WAIT | both resets held; counting consecutive synchronized lock
//  ST_CORE_UP   | core released, peripherals held for PERIPH_DELAY cycles
//  ST_RUN       | both resets released; watching lock and sw_rst_req
//  ST_SW_RST    | software pulse: both resets held for SW_RST_LEN cycles
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_WAIT    = 16,
   parameter int PERIPH_DELAY = 8,
   parameter int SW_RST_LEN   = 4
) (
   input  logic     clk,
   input  logic     reset_,
   rst_seq_if.slave bus
);

   localparam int CNT_MAX = max3(LOCK_WAIT, PERIPH_DELAY, SW_RST_LEN);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Terminal counts, pre-sized to the counter width
   localparam logic [CNT_W-1:0] LW_LAST = CNT_W'(LOCK_WAIT - 1);
   localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PERIPH_DELAY - 1);
   localparam logic [CNT_W-1:0] SR_LAST = CNT_W'(SW_RST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             locked_s;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   rst_cause_e       cause_q, cause_d;
   logic             chip_q, chip_d;
   logic             periph_q, periph_d;

   rst_seq_bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk),
      .rst_n (reset_),
      .d_i   (bus.locked),
      .q_o   (locked_s)
   );

   // Next-state, shared counter and cause selection
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_LOCK_WAIT: begin
            if (!locked_s) begin
               cnt_d = '0;
            end else if (cnt_q == LW_LAST) begin
               state_d = ST_CORE_UP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_CORE_UP: begin
            // Lock loss outranks the end of the peripheral delay
            if (!locked_s) begin
               state_d = ST_LOCK_WAIT;
               cnt_d   = '0;
               cause_d = CAUSE_LOCK;
            end else if (cnt_q == PD_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            // Lock loss outranks a coincident software request
            if (!locked_s) begin
               state_d = ST_LOCK_WAIT;
               cnt_d   = '0;
               cause_d = CAUSE_LOCK;
            end else if (bus.sw_rst_req) begin
               state_d = ST_SW_RST;
               cnt_d   = '0;
               cause_d = CAUSE_SW;
            end
         end
         ST_SW_RST: begin
            // The pulse always runs to completion, even if lock drops meanwhile
            if (cnt_q == SR_LAST) begin
               state_d = ST_LOCK_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOCK_WAIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Reset outputs decoded from the next state so they come straight off flops
   always_comb begin
      chip_d   = (state_d == ST_CORE_UP) || (state_d == ST_RUN);
      periph_d = (state_d == ST_RUN);
   end

   // State, counter, cause and registered reset outputs
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q  <= ST_LOCK_WAIT;
         cnt_q    <= '0;
         cause_q  <= CAUSE_POR;
         chip_q   <= 1'b0;
         periph_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cause_q  <= cause_d;
         chip_q   <= chip_d;
         periph_q <= periph_d;
      end
   end

   assign bus.chip_reset_   = chip_q;
   assign bus.periph_reset_ = periph_q;
   assign bus.rst_cause     = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: a cycle-level behavioural model built from
// elapsed-time counts is compared against the DUT on every falling clock edge,
// and a set of hand-derived edge numbers pins the model to the timing rules.
module tb_rst_seq;

   localparam int SYNC = 2;
   localparam int LW   = 16;
   localparam int PD   = 8;
   localparam int SR   = 4;

   logic clk    = 1'b0;
   logic reset_ = 1'b0;
   logic cmp_en = 1'b0;

   int checks = 0;
   int errors = 0;

   rst_seq_if bus ();

   rst_seq #(
      .SYNC_STAGES  (SYNC),
      .LOCK_WAIT    (LW),
      .PERIPH_DELAY (PD),
      .SW_RST_LEN   (SR)
   ) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Model: lock history, remaining sw pulse, time since core release,
   // length of current stable-lock run, and the recorded cause.
   typedef struct {
      logic [SYNC-1:0] hist;
      int              sw_left;
      bit              core_up;
      int              up_age;
      int              lock_run;
      logic [1:0]      cause;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_zero();
      mdl_t z;
      z.hist     = '0;
      z.sw_left  = 0;
      z.core_up  = 1'b0;
      z.up_age   = 0;
      z.lock_run = 0;
      z.cause    = 2'd0;
      return z;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t s, input logic lk, input logic sw);
      mdl_t n;
      logic ls;
      n  = s;
      ls = s.hist[SYNC-1];
      n.hist = {s.hist[SYNC-2:0], lk};
      if (s.sw_left > 0) begin
         n.sw_left = s.sw_left - 1;
         if (n.sw_left == 0) n.lock_run = 0;
      end else if (s.core_up) begin
         if (!ls) begin
            n.core_up  = 1'b0;
            n.lock_run = 0;
            n.cause    = 2'd1;
         end else if (s.up_age >= PD && sw) begin
            n.core_up = 1'b0;
            n.sw_left = SR;
            n.cause   = 2'd2;
         end else if (s.up_age < PD) begin
            n.up_age = s.up_age + 1;
         end
      end else begin
         if (ls) begin
            n.lock_run = s.lock_run + 1;
            if (n.lock_run >= LW) begin
               n.core_up  = 1'b1;
               n.up_age   = 0;
               n.lock_run = 0;
            end
         end else begin
            n.lock_run = 0;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset_) begin
      if (!reset_) m <= mdl_zero();
      else         m <= mdl_step(m, bus.locked, bus.sw_rst_req);
   end

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every falling edge, DUT against model
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_chip",   {1'b0, bus.chip_reset_},   {1'b0, m.core_up});
         check("model_periph", {1'b0, bus.periph_reset_},
               {1'b0, (m.core_up && m.up_age >= PD)});
         check("model_cause",  bus.rst_cause, m.cause);
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic lk);
      reset_         = 1'b0;
      bus.locked     = lk;
      bus.sw_rst_req = 1'b0;
      repeat (5) @(negedge clk);
      reset_ = 1'b1;
   endtask

   initial begin
      int drop;
      int r;
      bus.locked     = 1'b1;
      bus.sw_rst_req = 1'b0;

      // Power-on, with a software request inside CORE_UP that must be ignored
      do_reset(1'b1);
      cmp_en = 1'b1;
      check("por_cause0", bus.rst_cause, 2'd0);
      wait_edges(17);
      check("por_chip_e17", bus.chip_reset_, 1'b0);
      wait_edges(1);
      check("por_chip_e18", bus.chip_reset_, 1'b1);
      wait_edges(2);
      bus.sw_rst_req = 1'b1;
      wait_edges(1);
      bus.sw_rst_req = 1'b0;
      wait_edges(4);
      check("coreup_sw_periph_e25", bus.periph_reset_, 1'b0);
      check("coreup_sw_chip_e25", bus.chip_reset_, 1'b1);
      wait_edges(1);
      check("por_periph_e26", bus.periph_reset_, 1'b1);
      check("por_cause_e26", bus.rst_cause, 2'd0);
      wait_edges(4);

      // One-cycle lock drop in RUN
      bus.locked = 1'b0;
      wait_edges(1);
      bus.locked = 1'b1;
      check("drop_chip_k", bus.chip_reset_, 1'b1);
      wait_edges(1);
      check("drop_chip_k1", bus.chip_reset_, 1'b1);
      wait_edges(1);
      check("drop_chip_k2", bus.chip_reset_, 1'b0);
      check("drop_periph_k2", bus.periph_reset_, 1'b0);
      check("drop_cause_k2", bus.rst_cause, 2'd1);
      wait_edges(15);
      check("drop_chip_k17", bus.chip_reset_, 1'b0);
      wait_edges(1);
      check("drop_chip_k18", bus.chip_reset_, 1'b1);
      wait_edges(2);

      // Asynchronous reset in the middle of CORE_UP
      #2 reset_ = 1'b0;
      #1;
      check("async_chip", bus.chip_reset_, 1'b0);
      check("async_periph", bus.periph_reset_, 1'b0);
      check("async_cause", bus.rst_cause, 2'd0);
      @(negedge clk);
      wait_edges(2);
      reset_ = 1'b1;
      wait_edges(17);
      check("restart_chip_e17", bus.chip_reset_, 1'b0);
      wait_edges(1);
      check("restart_chip_e18", bus.chip_reset_, 1'b1);

      // Late lock: first edge sampling 1 is edge 10
      do_reset(1'b0);
      wait_edges(9);
      bus.locked = 1'b1;
      wait_edges(17);
      check("late_chip_e26", bus.chip_reset_, 1'b0);
      wait_edges(1);
      check("late_chip_e27", bus.chip_reset_, 1'b1);

      // Lock glitch at count 10 in LOCK_WAIT
      do_reset(1'b1);
      wait_edges(10);
      bus.locked = 1'b0;
      wait_edges(1);
      bus.locked = 1'b1;
      wait_edges(17);
      check("glitch_chip_e28", bus.chip_reset_, 1'b0);
      wait_edges(1);
      check("glitch_chip_e29", bus.chip_reset_, 1'b1);
      wait_edges(7);
      check("glitch_periph_e36", bus.periph_reset_, 1'b0);
      wait_edges(1);
      check("glitch_periph_e37", bus.periph_reset_, 1'b1);

      // Software reset from RUN
      wait_edges(3);
      bus.sw_rst_req = 1'b1;
      wait_edges(1);
      bus.sw_rst_req = 1'b0;
      check("sw_chip_s", bus.chip_reset_, 1'b0);
      check("sw_periph_s", bus.periph_reset_, 1'b0);
      check("sw_cause_s", bus.rst_cause, 2'd2);
      wait_edges(19);
      check("sw_chip_s19", bus.chip_reset_, 1'b0);
      wait_edges(1);
      check("sw_chip_s20", bus.chip_reset_, 1'b1);
      wait_edges(7);
      check("sw_periph_s27", bus.periph_reset_, 1'b0);
      wait_edges(1);
      check("sw_periph_s28", bus.periph_reset_, 1'b1);
      check("sw_cause_s28", bus.rst_cause, 2'd2);

      // Software request coincident with synchronized lock loss
      wait_edges(3);
      bus.locked = 1'b0;
      wait_edges(2);
      bus.sw_rst_req = 1'b1;
      wait_edges(1);
      bus.sw_rst_req = 1'b0;
      check("prio_cause", bus.rst_cause, 2'd1);
      check("prio_chip", bus.chip_reset_, 1'b0);
      wait_edges(3);
      bus.locked = 1'b1;
      wait_edges(30);

      // Randomized lock drops, sub-cycle glitches, sw requests, async resets
      drop = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         bus.sw_rst_req = ($urandom_range(0, 11) == 0);
         if (drop > 0) begin
            drop--;
            if (drop == 0) bus.locked = 1'b1;
         end else begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
               bus.locked = 1'b0;
               drop = $urandom_range(1, 3);
            end else if (r < 5) begin
               #1 bus.locked = 1'b0;
               #2 bus.locked = 1'b1;
            end else if (r == 5 && (i % 7) == 0) begin
               #2 reset_ = 1'b0;
               #1;
               check("rand_async_chip", bus.chip_reset_, 1'b0);
               check("rand_async_cause", bus.rst_cause, 2'd0);
               #1 reset_ = 1'b1;
            end
         end
      end
      @(negedge clk);
      bus.locked     = 1'b1;
      bus.sw_rst_req = 1'b0;
      wait_edges(40);
      check("final_chip", bus.chip_reset_, 1'b1);
      check("final_periph", bus.periph_reset_, 1'b1);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
